// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter onto one valid/ready slave port.
// A watchdog force-completes unacknowledged transfers and latches the address.
module bus_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        bus_error,
  output logic [31:0] err_addr
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_grant;
  logic [1:0]    w_grant_nx;
  logic          r_last;
  logic          w_last_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [31:0]   r_err_addr;
  logic [31:0]   w_err_addr_nx;

  logic          w_any;
  logic          w_pick1;
  logic          w_sel1;
  logic          w_expire;
  logic          w_done;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;

  // Winner: a lone requester wins; on contention, whoever was not last.
  assign w_any   = m0_valid | m1_valid;
  assign w_pick1 = m1_valid & (~m0_valid | ~r_last);

  // Request fields of the current owner; only driven out while busy.
  assign w_sel1  = r_grant[1];
  assign w_addr  = w_sel1 ? m1_addr  : m0_addr;
  assign w_wdata = w_sel1 ? m1_wdata : m0_wdata;
  assign w_wstrb = w_sel1 ? m1_wstrb : m0_wstrb;

  // A late s_ready on the last allowed cycle still wins over the watchdog.
  assign w_expire = (r_cnt == CNT_LAST) & ~s_ready;

  assign grant    = r_grant;
  assign err_addr = r_err_addr;

  // State, ownership, fairness pointer, watchdog count and fault address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_err_addr <= 32'h0;
    end else begin
      r_state    <= w_state_nx;
      r_grant    <= w_grant_nx;
      r_last     <= w_last_nx;
      r_cnt      <= w_cnt_nx;
      r_err_addr <= w_err_addr_nx;
    end
  end

  // Next-state logic and all slave/master-side outputs.
  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = r_grant;
    w_last_nx     = r_last;
    w_cnt_nx      = r_cnt;
    w_err_addr_nx = r_err_addr;
    w_done        = 1'b0;
    s_valid       = 1'b0;
    s_addr        = 32'h0;
    s_wdata       = 32'h0;
    s_wstrb       = 4'h0;
    m_rdata       = 32'h0;
    bus_error     = 1'b0;
    m0_ready      = 1'b0;
    m1_ready      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx = S_BUSY;
          w_grant_nx = w_pick1 ? 2'b10 : 2'b01;
          w_last_nx  = w_pick1;
          w_cnt_nx   = '0;
        end
      end
      S_BUSY: begin
        s_valid = 1'b1;
        s_addr  = w_addr;
        s_wdata = w_wdata;
        s_wstrb = w_wstrb;
        unique case (1'b1)
          s_ready: begin
            w_done  = 1'b1;
            m_rdata = s_rdata;
          end
          w_expire: begin
            w_done        = 1'b1;
            m_rdata       = ERR_DATA;
            bus_error     = 1'b1;
            w_err_addr_nx = w_addr;
          end
          default: begin
            w_cnt_nx = r_cnt + CW'(1);
          end
        endcase
        m0_ready = w_done & ~w_sel1;
        m1_ready = w_done & w_sel1;
        if (w_done) begin
          w_state_nx = S_IDLE;
          w_grant_nx = 2'b00;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plan plus randomized traffic for bus_arbiter,
// checked cycle by cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hdeadbeef;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        bus_error;
  logic [31:0] err_addr;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready),
    .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .bus_error(bus_error),
    .err_addr(err_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Stimulus state: per-master pending request, slave response.
  logic        v[2];
  logic [31:0] a[2];
  logic [31:0] d[2];
  logic [3:0]  st[2];
  logic        sr;
  logic [31:0] srd;
  int          mode;

  // Reference model: owner (-1 idle), cycles spent busy, fairness.
  int          cur;
  int          age;
  int          lastm;
  logic [31:0] e_err;
  int          rdy_cnt[2];
  int          berr_cnt;
  int          gq[$];

  task automatic model_reset();
    cur   = -1;
    age   = 0;
    lastm = 1;
    e_err = 32'h0;
  endtask

  task automatic drive();
    m0_valid = v[0];
    m0_addr  = a[0];
    m0_wdata = d[0];
    m0_wstrb = st[0];
    m1_valid = v[1];
    m1_addr  = a[1];
    m1_wdata = d[1];
    m1_wstrb = st[1];
    s_ready  = sr;
    s_rdata  = srd;
  endtask

  task automatic new_req(input int i);
    if ($urandom_range(0, 1) == 1)
      a[i] = 32'hffff0000 | (32'($urandom_range(0, 27)) << 2);
    else
      a[i] = $urandom;
    d[i]  = $urandom;
    st[i] = 4'($urandom_range(0, 15));
    v[i]  = 1'b1;
  endtask

  // One clock: starts and ends at a falling edge.
  task automatic cyc();
    logic        done;
    logic        tmo;
    logic [1:0]  eg;
    int          fin;
    done = 1'b0;
    tmo  = 1'b0;
    fin  = -1;
    drive();
    #1;
    if (cur < 0) begin
      check("grant_idle", {30'd0, grant}, 32'd0);
      check("s_valid_idle", {31'd0, s_valid}, 32'd0);
      check("s_addr_idle", s_addr, 32'd0);
      check("s_wdata_idle", s_wdata, 32'd0);
      check("s_wstrb_idle", {28'd0, s_wstrb}, 32'd0);
      check("m0_ready_idle", {31'd0, m0_ready}, 32'd0);
      check("m1_ready_idle", {31'd0, m1_ready}, 32'd0);
      check("m_rdata_idle", m_rdata, 32'd0);
      check("bus_error_idle", {31'd0, bus_error}, 32'd0);
    end else begin
      eg   = (cur == 1) ? 2'b10 : 2'b01;
      tmo  = !sr && (age == TO - 1);
      done = sr || tmo;
      check("grant", {30'd0, grant}, {30'd0, eg});
      check("s_valid", {31'd0, s_valid}, 32'd1);
      check("s_addr", s_addr, a[cur]);
      check("s_wdata", s_wdata, d[cur]);
      check("s_wstrb", {28'd0, s_wstrb}, {28'd0, st[cur]});
      check("m0_ready", {31'd0, m0_ready},
            32'(done && cur == 0));
      check("m1_ready", {31'd0, m1_ready},
            32'(done && cur == 1));
      check("bus_error", {31'd0, bus_error}, 32'(tmo));
      if (done)
        check("m_rdata", m_rdata, sr ? srd : ERR);
    end
    check("err_addr", err_addr, e_err);
    @(posedge clk);
    if (cur >= 0) begin
      if (done) begin
        if (tmo) begin
          e_err = a[cur];
          berr_cnt++;
        end
        rdy_cnt[cur]++;
        fin = cur;
        cur = -1;
      end else begin
        age++;
      end
    end else if (v[0] || v[1]) begin
      if (v[0] && v[1]) cur = 1 - lastm;
      else cur = v[1] ? 1 : 0;
      lastm = cur;
      age   = 0;
      gq.push_back(cur);
    end
    @(negedge clk);
    if (fin >= 0) begin
      if (mode == 1) new_req(fin);
      else if (mode == 2 && $urandom_range(0, 1) == 1) new_req(fin);
      else v[fin] = 1'b0;
    end
    if (mode == 2) begin
      for (int i = 0; i < 2; i++)
        if (!v[i] && $urandom_range(0, 3) == 0) new_req(i);
      sr  = ($urandom_range(0, 9) < 3);
      srd = $urandom;
    end
  endtask

  task automatic do_reset();
    v[0] = 1'b0;
    v[1] = 1'b0;
    sr   = 1'b0;
    drive();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clr_stats();
    rdy_cnt[0] = 0;
    rdy_cnt[1] = 0;
    berr_cnt   = 0;
    gq.delete();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0; st[i] = '0;
    end
    sr = 1'b0; srd = '0; mode = 0;
    clr_stats();
    @(negedge clk);
    do_reset();

    // Reset state, then single m0 read with a zero-wait slave.
    cyc();
    a[0] = 32'hffff0010; d[0] = 32'h0; st[0] = 4'h0;
    v[0] = 1'b1; sr = 1'b1; srd = 32'h12345678;
    cyc();
    check("single_grant", {30'd0, grant}, 32'd1);
    cyc();
    check("single_rdy", 32'(rdy_cnt[0]), 32'd1);
    cyc();

    // Contention from reset: strict alternation.
    do_reset();
    clr_stats();
    mode = 1;
    new_req(0);
    new_req(1);
    sr = 1'b1;
    repeat (8) cyc();
    check("cont_n", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < gq.size())
        check("cont_order", 32'(gq[i]), 32'(i % 2));
    check("cont_rdy0", 32'(rdy_cnt[0]), 32'd2);
    check("cont_rdy1", 32'(rdy_cnt[1]), 32'd2);
    mode = 0;

    // Timeout on m1 read with a silent slave.
    do_reset();
    clr_stats();
    a[1] = 32'hffff0050; d[1] = 32'h0; st[1] = 4'h0;
    v[1] = 1'b1; sr = 1'b0; srd = 32'h55aa55aa;
    repeat (TO + 1) cyc();
    check("to_berr", 32'(berr_cnt), 32'd1);
    check("to_rdy1", 32'(rdy_cnt[1]), 32'd1);
    cyc();
    check("to_err_addr", err_addr, 32'hffff0050);
    check("to_grant", {30'd0, grant}, 32'd0);

    // Boundary: slave answers in the last allowed cycle.
    clr_stats();
    a[0] = 32'hffff0020; d[0] = 32'h0; st[0] = 4'h0;
    v[0] = 1'b1; sr = 1'b0; srd = 32'hcafef00d;
    repeat (TO) cyc();
    sr = 1'b1;
    cyc();
    sr = 1'b0;
    check("bnd_berr", 32'(berr_cnt), 32'd0);
    check("bnd_rdy0", 32'(rdy_cnt[0]), 32'd1);
    check("bnd_err_addr", err_addr, 32'hffff0050);
    cyc();

    // Reset while busy on m0.
    clr_stats();
    a[0] = 32'hffff0030; d[0] = 32'h1; st[0] = 4'hf;
    v[0] = 1'b1; sr = 1'b0;
    cyc();
    cyc();
    #2;
    resetn = 1'b0;
    #1;
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_s_valid", {31'd0, s_valid}, 32'd0);
    check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    check("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    check("rst_berr", {31'd0, bus_error}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    new_req(0);
    new_req(1);
    sr = 1'b1;
    resetn = 1'b1;
    cyc();
    check("rst_first", {30'd0, grant}, 32'd1);
    repeat (3) cyc();
    check("rst_rdy0", 32'(rdy_cnt[0]), 32'd1);
    check("rst_rdy1", 32'(rdy_cnt[1]), 32'd1);

    // Idle hygiene: slave noise with no requests.
    do_reset();
    clr_stats();
    for (int i = 0; i < 20; i++) begin
      sr  = 1'($urandom_range(0, 1));
      srd = $urandom;
      cyc();
    end
    check("idle_rdy", 32'(rdy_cnt[0] + rdy_cnt[1]), 32'd0);
    check("idle_berr", 32'(berr_cnt), 32'd0);

    // Random traffic with a stalling slave.
    do_reset();
    clr_stats();
    mode = 2;
    repeat (800) cyc();
    mode = 0;
    sr = 1'b1;
    for (int i = 0; i < 20 && (v[0] || v[1]); i++) cyc();
    check("drain", 32'({v[0], v[1]}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
